// File: rtl/integrate_dump_if.sv
// Sample-in / symbol-out handshake bundle for the integrate-and-dump stage.
// master = upstream/downstream environment side, slave = the integrate_dump block.
interface integrate_dump_if #(
    parameter int DATA_W = 25,
    parameter int SPS    = 8
);
    localparam int ACC_W = DATA_W + $clog2(SPS);

    logic                     i_valid;
    logic signed [DATA_W-1:0] i_data;
    logic                     i_sync;
    logic                     i_ready;
    logic                     o_ready;
    logic                     o_valid;
    logic signed [ACC_W-1:0]  o_sum;
    logic                     o_bit;
    logic                     o_slip;

    modport master (
        output i_valid, i_data, i_sync, i_ready,
        input  o_ready, o_valid, o_sum, o_bit, o_slip
    );

    modport slave (
        input  i_valid, i_data, i_sync, i_ready,
        output o_ready, o_valid, o_sum, o_bit, o_slip
    );
endinterface

// File: rtl/integrate_dump.sv
// Integrate-and-dump: sums SPS signed difference samples per symbol and emits
// the sum with a hard-decision bit; i_sync restarts the symbol on its sample.
module integrate_dump #(
    parameter int DATA_W = 25,
    parameter int SPS    = 8
) (
    input  logic             clk,
    input  logic             reset,
    integrate_dump_if.slave  bus
);
    localparam int ACC_W = DATA_W + $clog2(SPS);
    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_sum;
    logic                    r_valid;
    logic                    r_bit;
    logic                    r_slip;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_dump;
    logic signed [ACC_W-1:0] w_sample;
    logic signed [ACC_W-1:0] w_total;

    // Output register is free, or its symbol leaves on this same edge.
    assign w_ready  = !reset && (!r_valid || bus.i_ready);
    assign w_accept = bus.i_valid && w_ready;
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_dump   = w_accept && !bus.i_sync && w_last;
    assign w_sample = {{(ACC_W - DATA_W){bus.i_data[DATA_W-1]}}, bus.i_data};
    assign w_total  = r_acc + w_sample;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_valid <= 1'b0;
            r_bit   <= 1'b0;
            r_slip  <= 1'b0;
        end else begin
            r_slip <= w_accept && bus.i_sync && (r_cnt != '0);

            if (w_accept) begin
                if (bus.i_sync) begin
                    r_acc <= w_sample;
                    r_cnt <= CNT_W'(1);
                end else if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_total;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // A dump on the draining edge reloads the register with no bubble.
            if (w_dump) begin
                r_sum   <= w_total;
                r_bit   <= !w_total[ACC_W-1];
                r_valid <= 1'b1;
            end else if (r_valid && bus.i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_sum   = r_sum;
    assign bus.o_bit   = r_bit;
    assign bus.o_slip  = r_slip;
endmodule
